// File: rtl/tf530_bus_pkg.sv
// Shared types and DSACK encodings for the 68030-side Zorro II cycle sequencer.
package tf530_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_WAIT,
    ST_ACK,
    ST_BERR
  } state_t;

  typedef enum logic [1:0] {
    T_NONE,
    T_AC,
    T_RAM,
    T_IO
  } target_t;

  localparam logic [1:0] DSACK_8    = 2'b10;
  localparam logic [1:0] DSACK_16   = 2'b01;
  localparam logic [1:0] DSACK_32   = 2'b00;
  localparam logic [1:0] DSACK_IDLE = 2'b11;

  // Port-size acknowledge for a claimed target.
  function automatic logic [1:0] dsack_of(input target_t t);
    logic [1:0] r;
    case (t)
      T_AC:    r = DSACK_8;
      T_IO:    r = DSACK_16;
      T_RAM:   r = DSACK_32;
      default: r = DSACK_IDLE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tf_sync2.sv
// Two-flop synchroniser for an asynchronous active-low strobe; resets to the inactive level.
module tf_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/zbus_cycle_ctrl.sv
// 68030 cycle sequencer for autoconfig and board-space windows: target select,
// per-target wait states, DSACK sizing, chip enables and unclaimed-cycle timeout.
module zbus_cycle_ctrl
  import tf530_bus_pkg::*;
#(
  parameter int unsigned AC_WAIT  = 2,
  parameter int unsigned RAM_WAIT = 0,
  parameter int unsigned IO_WAIT  = 4,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       AS20,
  input  logic       DS20,
  input  logic       RW20,
  input  logic       ACCESS,
  input  logic [1:0] DECODE,
  output logic [1:0] DSACK,
  output logic       BERR,
  output logic       DOE,
  output logic       RAM_CE,
  output logic       IO_CE,
  output logic       BUSY
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic          as_s;
  logic          ds_s;
  logic [1:0]    fill;
  logic          armed;
  state_t        state;
  target_t       target;
  logic          rw;
  logic [CW-1:0] cnt;

  target_t       pick_c;
  logic [CW-1:0] load_c;
  logic          hold_c;
  logic          ram_sel_c;
  logic          io_sel_c;
  logic          doe_c;

  tf_sync2 u_as_sync (.clk(CLK), .rst(RST), .d(AS20), .q(as_s));
  tf_sync2 u_ds_sync (.clk(CLK), .rst(RST), .d(DS20), .q(ds_s));

  // Fixed-priority target pick and its wait/timeout load value.
  always_comb begin
    pick_c = T_NONE;
    if (!ACCESS)         pick_c = T_AC;
    else if (!DECODE[0]) pick_c = T_RAM;
    else if (!DECODE[1]) pick_c = T_IO;
    case (pick_c)
      T_AC:    load_c = CW'(AC_WAIT);
      T_RAM:   load_c = CW'(RAM_WAIT);
      T_IO:    load_c = CW'(IO_WAIT);
      default: load_c = CW'(TIMEOUT);
    endcase
  end

  always_comb begin
    hold_c    = (target == T_AC) && !rw && ds_s;
    ram_sel_c = (target == T_RAM);
    io_sel_c  = (target == T_IO);
    doe_c     = (target == T_AC) && rw;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ST_IDLE;
      target <= T_NONE;
      rw     <= 1'b1;
      cnt    <= '0;
      armed  <= 1'b0;
      fill   <= 2'b00;
      DSACK  <= DSACK_IDLE;
      BERR   <= 1'b1;
      DOE    <= 1'b0;
      RAM_CE <= 1'b1;
      IO_CE  <= 1'b1;
      BUSY   <= 1'b0;
    end else begin
      // The synchroniser reset value is not a real sample of AS20, so arming waits
      // until the pipeline holds genuine samples.
      fill <= {fill[0], 1'b1};
      if (as_s && fill[1]) armed <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (!as_s && armed) begin
            state  <= ST_SELECT;
            target <= pick_c;
            rw     <= RW20;
            cnt    <= load_c;
            armed  <= 1'b0;
            BUSY   <= 1'b1;
          end
        end

        ST_SELECT: begin
          if (as_s) begin
            state  <= ST_IDLE;
            DOE    <= 1'b0;
            RAM_CE <= 1'b1;
            IO_CE  <= 1'b1;
            BUSY   <= 1'b0;
          end else begin
            RAM_CE <= !ram_sel_c;
            IO_CE  <= !io_sel_c;
            DOE    <= doe_c;
            if (cnt != '0 || hold_c) begin
              state <= ST_WAIT;
            end else if (target == T_NONE) begin
              state <= ST_BERR;
              BERR  <= 1'b0;
            end else begin
              state <= ST_ACK;
              DSACK <= dsack_of(target);
            end
          end
        end

        ST_WAIT: begin
          if (as_s) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            DOE    <= 1'b0;
            RAM_CE <= 1'b1;
            IO_CE  <= 1'b1;
            BUSY   <= 1'b0;
          end else if (cnt > CW'(1)) begin
            cnt <= cnt - CW'(1);
          end else if (hold_c) begin
            cnt <= '0;
          end else if (target == T_NONE) begin
            cnt   <= '0;
            state <= ST_BERR;
            BERR  <= 1'b0;
          end else begin
            cnt   <= '0;
            state <= ST_ACK;
            DSACK <= dsack_of(target);
          end
        end

        ST_ACK, ST_BERR: begin
          if (as_s) begin
            state  <= ST_IDLE;
            DSACK  <= DSACK_IDLE;
            BERR   <= 1'b1;
            DOE    <= 1'b0;
            RAM_CE <= 1'b1;
            IO_CE  <= 1'b1;
            BUSY   <= 1'b0;
          end
        end

        default: begin
          state  <= ST_IDLE;
          DSACK  <= DSACK_IDLE;
          BERR   <= 1'b1;
          DOE    <= 1'b0;
          RAM_CE <= 1'b1;
          IO_CE  <= 1'b1;
          BUSY   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zbus_cycle_ctrl.sv
// Directed bench for zbus_cycle_ctrl; cycle offsets k count posedges after AS20 is driven low.
module tb_zbus_cycle_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       AS20 = 1'b1;
  logic       DS20 = 1'b1;
  logic       RW20 = 1'b1;
  logic       ACCESS = 1'b1;
  logic [1:0] DECODE = 2'b11;
  logic [1:0] DSACK;
  logic       BERR;
  logic       DOE;
  logic       RAM_CE;
  logic       IO_CE;
  logic       BUSY;

  int tests_run    = 0;
  int tests_failed = 0;

  zbus_cycle_ctrl dut (
    .CLK(CLK), .RST(RST), .AS20(AS20), .DS20(DS20), .RW20(RW20),
    .ACCESS(ACCESS), .DECODE(DECODE), .DSACK(DSACK), .BERR(BERR),
    .DOE(DOE), .RAM_CE(RAM_CE), .IO_CE(IO_CE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic idle_bus();
    AS20 = 1'b1; DS20 = 1'b1; RW20 = 1'b1; ACCESS = 1'b1; DECODE = 2'b11;
    cyc(4);
  endtask

  task automatic start(input logic rw, input logic acc, input logic [1:0] dec);
    RW20 = rw; ACCESS = acc; DECODE = dec; AS20 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(3);
    check("rst_dsack", int'(DSACK), 3);
    check("rst_berr", int'(BERR), 1);
    check("rst_doe", int'(DOE), 0);
    check("rst_ram_ce", int'(RAM_CE), 1);
    check("rst_io_ce", int'(IO_CE), 1);
    check("rst_busy", int'(BUSY), 0);
    RST = 1'b0;
    cyc(5);

    // AC read, 2 waits: E at k=3, DSACK 8-bit at k=6
    start(1'b1, 1'b0, 2'b11);
    cyc(3); check("ac_busy_e", int'(BUSY), 1);
    cyc(1); check("ac_doe_e1", int'(DOE), 1); check("ac_dsack_k4", int'(DSACK), 3);
    cyc(1); check("ac_dsack_k5", int'(DSACK), 3);
    cyc(1); check("ac_dsack_k6", int'(DSACK), 2); check("ac_doe_ack", int'(DOE), 1);
    AS20 = 1'b1;
    cyc(2); check("ac_dsack_hold", int'(DSACK), 2);
    cyc(1); check("ac_dsack_rel", int'(DSACK), 3);
    check("ac_doe_rel", int'(DOE), 0); check("ac_busy_rel", int'(BUSY), 0);
    idle_bus();

    // RAM read, zero waits: DSACK 32-bit at E+1
    start(1'b1, 1'b1, 2'b10);
    cyc(3); check("ram_dsack_e", int'(DSACK), 3);
    cyc(1); check("ram_dsack_e1", int'(DSACK), 0);
    check("ram_ce_e1", int'(RAM_CE), 0); check("ram_io_ce", int'(IO_CE), 1);
    AS20 = 1'b1;
    cyc(3); check("ram_ce_rel", int'(RAM_CE), 1); check("ram_dsack_rel", int'(DSACK), 3);
    idle_bus();

    // AC write held off by DS20
    start(1'b0, 1'b0, 2'b11);
    for (int k = 1; k <= 5; k++) begin
      cyc(1);
      check("acw_dsack_wait", int'(DSACK), 3);
      check("acw_doe_wait", int'(DOE), 0);
    end
    DS20 = 1'b0;
    cyc(1); check("acw_dsack_ds1", int'(DSACK), 3);
    cyc(1); check("acw_dsack_ds2", int'(DSACK), 3);
    cyc(1); check("acw_dsack_ds3", int'(DSACK), 2); check("acw_doe_ack", int'(DOE), 0);
    AS20 = 1'b1;
    cyc(3); check("acw_dsack_rel", int'(DSACK), 3);
    idle_bus();

    // Unclaimed cycle: BERR at E+256 = k=259
    start(1'b1, 1'b1, 2'b11);
    cyc(258); check("to_berr_k258", int'(BERR), 1); check("to_busy", int'(BUSY), 1);
    cyc(1); check("to_berr_k259", int'(BERR), 0); check("to_dsack", int'(DSACK), 3);
    AS20 = 1'b1;
    cyc(3); check("to_berr_rel", int'(BERR), 1); check("to_busy_rel", int'(BUSY), 0);
    idle_bus();

    // Priority: ACCESS beats both DECODE hits
    start(1'b1, 1'b0, 2'b00);
    cyc(4); check("pri_ram_ce", int'(RAM_CE), 1); check("pri_io_ce", int'(IO_CE), 1);
    check("pri_doe", int'(DOE), 1);
    cyc(2); check("pri_dsack", int'(DSACK), 2);
    AS20 = 1'b1;
    cyc(3);
    idle_bus();

    // Abort: IO cycle, AS20 released right after E
    start(1'b1, 1'b1, 2'b01);
    cyc(3);
    AS20 = 1'b1;
    cyc(1); check("ab_io_ce_k4", int'(IO_CE), 0);
    cyc(1); check("ab_io_ce_k5", int'(IO_CE), 0); check("ab_busy_k5", int'(BUSY), 1);
    cyc(1); check("ab_io_ce_k6", int'(IO_CE), 1); check("ab_busy_k6", int'(BUSY), 0);
    for (int k = 0; k < 6; k++) begin
      cyc(1);
      check("ab_dsack", int'(DSACK), 3);
      check("ab_berr", int'(BERR), 1);
    end
    idle_bus();

    // Reset during IO wait with AS20 held low
    start(1'b1, 1'b1, 2'b01);
    cyc(5); check("rw_io_ce", int'(IO_CE), 0); check("rw_busy", int'(BUSY), 1);
    RST = 1'b1;
    cyc(1);
    check("rw_rst_dsack", int'(DSACK), 3); check("rw_rst_io_ce", int'(IO_CE), 1);
    check("rw_rst_busy", int'(BUSY), 0); check("rw_rst_berr", int'(BERR), 1);
    RST = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      check("rw_noack_dsack", int'(DSACK), 3);
      check("rw_noack_busy", int'(BUSY), 0);
    end
    AS20 = 1'b1;
    cyc(5);
    start(1'b1, 1'b1, 2'b01);
    cyc(7); check("rw_new_k7", int'(DSACK), 3);
    cyc(1); check("rw_new_k8", int'(DSACK), 1); check("rw_new_io_ce", int'(IO_CE), 0);
    AS20 = 1'b1;
    cyc(3); check("rw_new_rel", int'(DSACK), 3);
    idle_bus();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
